// File: rtl/corner_tracker.sv
// rtl/corner_tracker.sv - per-frame extreme-corner tracker over detected pixels
// Stage 1 registers the pixel with s=x+y and d=x-y; stage 2 folds it into the accumulators.
module corner_tracker #(
  parameter int XW         = 10,
  parameter int MIN_PIXELS = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pixel_valid,
  input  logic [XW-1:0] x,
  input  logic [XW-1:0] y,
  input  logic          detected,
  input  logic          frame_start,
  input  logic          frame_end,
  output logic [XW-1:0] tl_x,
  output logic [XW-1:0] tl_y,
  output logic [XW-1:0] tr_x,
  output logic [XW-1:0] tr_y,
  output logic [XW-1:0] bl_x,
  output logic [XW-1:0] bl_y,
  output logic [XW-1:0] br_x,
  output logic [XW-1:0] br_y,
  output logic          corners_valid,
  output logic [18:0]   pixel_count,
  output logic          frame_done
);

  localparam int MW = XW + 1;
  localparam logic [MW-1:0]        S_HI  = '1;
  localparam logic signed [MW-1:0] D_NEG = {1'b1, {XW{1'b0}}};
  localparam logic signed [MW-1:0] D_POS = {1'b0, {XW{1'b1}}};
  localparam logic [18:0]          MIN_CNT = 19'(MIN_PIXELS);

  typedef enum logic [1:0] {WAIT_SOF, ACCUM, LATCH} state_t;
  state_t state;

  logic                   hit1, fe1;
  logic [XW-1:0]          x1, y1;
  logic [MW-1:0]          s1;
  logic signed [MW-1:0]   d1;

  logic [MW-1:0]          s_min, s_max, n_s_min, n_s_max;
  logic signed [MW-1:0]   d_min, d_max, n_d_min, n_d_max;
  logic [XW-1:0]          a_tl_x, a_tl_y, a_tr_x, a_tr_y, a_bl_x, a_bl_y, a_br_x, a_br_y;
  logic [XW-1:0]          n_tl_x, n_tl_y, n_tr_x, n_tr_y, n_bl_x, n_bl_y, n_br_x, n_br_y;
  logic [18:0]            cnt, n_cnt;
  logic                   hit, n_hit;

  // Next accumulator values including the pixel now in stage 1; also what LATCH copies out.
  always_comb begin
    n_s_min = s_min;  n_s_max = s_max;  n_d_min = d_min;  n_d_max = d_max;
    n_tl_x = a_tl_x;  n_tl_y = a_tl_y;  n_tr_x = a_tr_x;  n_tr_y = a_tr_y;
    n_bl_x = a_bl_x;  n_bl_y = a_bl_y;  n_br_x = a_br_x;  n_br_y = a_br_y;
    n_cnt  = cnt;
    n_hit  = hit;
    if (state == ACCUM && hit1) begin
      if (s1 < s_min) begin n_s_min = s1; n_tl_x = x1; n_tl_y = y1; end
      if (s1 > s_max) begin n_s_max = s1; n_br_x = x1; n_br_y = y1; end
      if (d1 > d_max) begin n_d_max = d1; n_tr_x = x1; n_tr_y = y1; end
      if (d1 < d_min) begin n_d_min = d1; n_bl_x = x1; n_bl_y = y1; end
      if (cnt != '1) n_cnt = cnt + 19'd1;
      n_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_SOF;
      hit1 <= 1'b0;  fe1 <= 1'b0;  x1 <= '0;  y1 <= '0;  s1 <= '0;  d1 <= '0;
      s_min <= S_HI;  s_max <= '0;  d_min <= D_POS;  d_max <= D_NEG;
      a_tl_x <= '0;  a_tl_y <= '0;  a_tr_x <= '0;  a_tr_y <= '0;
      a_bl_x <= '0;  a_bl_y <= '0;  a_br_x <= '0;  a_br_y <= '0;
      cnt <= '0;  hit <= 1'b0;
      tl_x <= '0;  tl_y <= '0;  tr_x <= '0;  tr_y <= '0;
      bl_x <= '0;  bl_y <= '0;  br_x <= '0;  br_y <= '0;
      corners_valid <= 1'b0;  pixel_count <= '0;  frame_done <= 1'b0;
    end else begin
      hit1 <= pixel_valid & detected;
      fe1  <= frame_end;
      x1   <= x;
      y1   <= y;
      s1   <= {1'b0, x} + {1'b0, y};
      d1   <= $signed({1'b0, x}) - $signed({1'b0, y});

      frame_done <= 1'b0;
      if (state == ACCUM && fe1) begin
        tl_x <= n_tl_x;  tl_y <= n_tl_y;  tr_x <= n_tr_x;  tr_y <= n_tr_y;
        bl_x <= n_bl_x;  bl_y <= n_bl_y;  br_x <= n_br_x;  br_y <= n_br_y;
        pixel_count   <= n_cnt;
        corners_valid <= n_hit && (n_cnt >= MIN_CNT);
        frame_done    <= 1'b1;
      end

      // frame_start in any state (re)opens a frame after any copy-out above.
      if (frame_start) begin
        s_min <= S_HI;  s_max <= '0;  d_min <= D_POS;  d_max <= D_NEG;
        a_tl_x <= '0;  a_tl_y <= '0;  a_tr_x <= '0;  a_tr_y <= '0;
        a_bl_x <= '0;  a_bl_y <= '0;  a_br_x <= '0;  a_br_y <= '0;
        cnt <= '0;  hit <= 1'b0;
      end else begin
        s_min <= n_s_min;  s_max <= n_s_max;  d_min <= n_d_min;  d_max <= n_d_max;
        a_tl_x <= n_tl_x;  a_tl_y <= n_tl_y;  a_tr_x <= n_tr_x;  a_tr_y <= n_tr_y;
        a_bl_x <= n_bl_x;  a_bl_y <= n_bl_y;  a_br_x <= n_br_x;  a_br_y <= n_br_y;
        cnt <= n_cnt;  hit <= n_hit;
      end

      case (state)
        WAIT_SOF: if (frame_start) state <= ACCUM;
        ACCUM:    if (frame_start) state <= ACCUM;
                  else if (fe1)    state <= LATCH;
        LATCH:    state <= frame_start ? ACCUM : WAIT_SOF;
        default:  state <= WAIT_SOF;
      endcase
    end
  end

endmodule

// File: tb/tb_corner_tracker.sv
// tb/tb_corner_tracker.sv - scoreboard bench for corner_tracker
// Expected corners come from a per-frame list of detected pixels searched for first-seen extremes.
module tb_corner_tracker;
  localparam int XW   = 10;
  localparam int MINP = 16;

  logic clk = 1'b0, reset = 1'b1;
  logic pixel_valid = 1'b0, detected = 1'b0, frame_start = 1'b0, frame_end = 1'b0;
  logic [XW-1:0] x = '0, y = '0;
  logic [XW-1:0] tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y;
  logic corners_valid, frame_done;
  logic [18:0] pixel_count;

  corner_tracker #(.XW(XW), .MIN_PIXELS(MINP)) dut (
    .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .x(x), .y(y), .detected(detected),
    .frame_start(frame_start), .frame_end(frame_end),
    .tl_x(tl_x), .tl_y(tl_y), .tr_x(tr_x), .tr_y(tr_y),
    .bl_x(bl_x), .bl_y(bl_y), .br_x(br_x), .br_y(br_y),
    .corners_valid(corners_valid), .pixel_count(pixel_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [9:0] tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y;
    logic        v;
    logic [18:0] n;
  } res_t;
  typedef struct packed { logic [9:0] x, y; } pix_t;

  res_t exp_q[$];
  int   exp_cyc_q[$];
  res_t last = '0;
  pix_t cur[$];
  logic in_frame = 1'b0;
  int   checks = 0, passes = 0;

  res_t act;
  assign act = {tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y, corners_valid, pixel_count};

  function automatic string fmt(input res_t r);
    return $sformatf("TL(%0d,%0d) TR(%0d,%0d) BL(%0d,%0d) BR(%0d,%0d) valid=%0d count=%0d",
                     r.tl_x, r.tl_y, r.tr_x, r.tr_y, r.bl_x, r.bl_y, r.br_x, r.br_y, r.v, r.n);
  endfunction

  task automatic chk(input string nm, input logic ok, input string det);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %s", nm, det);
  endtask

  function automatic int sv(input int i);
    return int'(cur[i].x) + int'(cur[i].y);
  endfunction
  function automatic int dv(input int i);
    return int'(cur[i].x) - int'(cur[i].y);
  endfunction

  // First pixel in arrival order reaching each extreme; empty frame reports all zeros.
  function automatic res_t model();
    res_t r = '0;
    int ti = 0, ri = 0, bi = 0, ki = 0;
    if (cur.size() == 0) return r;
    for (int i = 1; i < cur.size(); i++) begin
      if (sv(i) < sv(ti)) ti = i;
      if (sv(i) > sv(ki)) ki = i;
      if (dv(i) > dv(ri)) ri = i;
      if (dv(i) < dv(bi)) bi = i;
    end
    r.tl_x = cur[ti].x;  r.tl_y = cur[ti].y;
    r.tr_x = cur[ri].x;  r.tr_y = cur[ri].y;
    r.bl_x = cur[bi].x;  r.bl_y = cur[bi].y;
    r.br_x = cur[ki].x;  r.br_y = cur[ki].y;
    r.n = (cur.size() > 524287) ? 19'h7FFFF : 19'(cur.size());
    r.v = (cur.size() >= MINP);
    return r;
  endfunction

  task automatic drv(input logic pv, input logic det, input logic fs, input logic fe,
                     input int xx, input int yy);
    pix_t p;
    @(posedge clk); #1;
    pixel_valid = pv;  detected = det;  frame_start = fs;  frame_end = fe;
    x = 10'(xx);  y = 10'(yy);
    if (fs) begin cur.delete(); in_frame = 1'b1; end
    if (pv && det) begin p.x = 10'(xx); p.y = 10'(yy); cur.push_back(p); end
    if (fe && in_frame) begin
      exp_q.push_back(model());
      exp_cyc_q.push_back(cyc + 2);
      in_frame = 1'b0;
    end
  endtask

  task automatic idle();        drv(0, 0, 0, 0, 0, 0);   endtask
  task automatic sof();         drv(0, 0, 1, 0, 0, 0);   endtask
  task automatic eof();         drv(0, 0, 0, 1, 0, 0);   endtask
  task automatic px(input int xx, input int yy); drv(1, 1, 0, 0, xx, yy); endtask
  task automatic rnd_px();
    drv(($urandom % 4) != 0, $urandom % 2, 0, 0, $urandom_range(0, 639), $urandom_range(0, 479));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain", exp_q.size() == 0, $sformatf("pending=%0d required=0", exp_q.size()));
  endtask

  // Monitor: compare on every frame_done, otherwise require outputs to hold.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_done", 1'b0, $sformatf("got %s at cycle %0d, required none", fmt(act), cyc));
        end else begin
          res_t e;
          int   ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk("frame_result", act == e, $sformatf("got %s required %s", fmt(act), fmt(e)));
          chk("frame_done_cycle", cyc == ec, $sformatf("got %0d required %0d", cyc, ec));
          last = e;
        end
      end else begin
        chk("hold", act == last, $sformatf("cycle %0d got %s required %s", cyc, fmt(act), fmt(last)));
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_outputs", act == '0, $sformatf("got %s required all zero", fmt(act)));
    chk("reset_frame_done", frame_done == 1'b0, $sformatf("got %0d required 0", frame_done));

    // single pixel
    sof(); idle(); px(100, 50); idle(); eof(); repeat (4) idle();

    // quadrilateral with interior hits
    sof();
    px(10, 20);
    for (int i = 0; i < 10; i++) px(300 + i, 200 + i);
    px(600, 15); px(5, 400);
    for (int i = 0; i < 10; i++) px(320 - i, 250 + i);
    px(630, 470); eof(); repeat (3) idle();

    // tie on s: first arrival wins
    sof(); px(5, 5); px(4, 6); eof(); repeat (3) idle();

    // 15 detected pixels: below threshold
    sof();
    for (int i = 0; i < 15; i++) px(50 + 3 * i, 60 + 2 * i);
    eof(); repeat (3) idle();

    // 16th pixel arrives with frame_end and is the BR corner
    sof();
    for (int i = 0; i < 15; i++) px(50 + 3 * i, 60 + 2 * i);
    drv(1, 1, 0, 1, 639, 479); repeat (3) idle();

    // no detected pixels
    sof(); drv(1, 0, 0, 0, 7, 8); drv(1, 0, 0, 0, 600, 9); idle(); eof(); repeat (3) idle();

    // abort mid-frame
    sof(); px(1, 1); px(638, 2); px(3, 470); sof(); px(200, 100); px(210, 90); eof();
    // back-to-back: next frame_start in the cycle right after the previous done-producing frame_end
    sof(); px(320, 240); px(321, 250); eof();
    sof(); px(400, 300); eof();
    idle(); sof(); px(12, 34); px(56, 78); eof(); repeat (4) idle();
    wait_drain();

    // reset mid-frame discards the frame
    sof(); px(100, 100); px(200, 200);
    @(posedge clk); #1;
    reset = 1'b1;  pixel_valid = 0;  detected = 0;  frame_start = 0;  frame_end = 0;
    in_frame = 1'b0;  cur.delete();
    @(posedge clk); #1;
    reset = 1'b0;  last = '0;
    chk("midreset_outputs", act == '0, $sformatf("got %s required all zero", fmt(act)));
    chk("midreset_frame_done", frame_done == 1'b0, $sformatf("got %0d required 0", frame_done));
    px(300, 300); eof(); repeat (5) idle();
    sof(); px(77, 88); px(99, 11); eof(); repeat (3) idle();

    // randomized frames, one with a mid-frame abort
    for (int k = 0; k < 8; k++) begin
      sof();
      n = $urandom_range(20, 150);
      for (int i = 0; i < n; i++) begin
        if (k == 3 && i == n / 2) sof();
        else rnd_px();
      end
      drv(($urandom % 2) != 0, $urandom % 2, 0, 1, $urandom_range(0, 639), $urandom_range(0, 479));
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) idle();
    end
    repeat (4) idle();
    wait_drain();
    repeat (3) idle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/corner_tracker.md
# corner_tracker

Per-frame corner extractor that sits directly downstream of the colour detector. For every flagged pixel it tracks the four extreme points of the detected region: top-left, top-right, bottom-left and bottom-right. At end of frame it latches those corners so the perspective/warp logic can read a stable quadrilateral for the whole next frame. It uses a two-stage pipeline with double-buffered outputs.

## Interface

Parameters
- XW, 10, coordinate width (x, y unsigned)
- MIN_PIXELS, 16, minimum detected-pixel count for the frame's corners to be declared valid

Ports
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pixel_valid  input  1  x, y, detected describe a live pixel this cycle
- x  input  XW  pixel column
- y  input  XW  pixel row
- detected  input  1  colour-match flag for this pixel (corner_detected of the upstream stage)
- frame_start  input  1  one-cycle pulse before the first pixel of a frame
- frame_end  input  1  one-cycle pulse; a pixel presented in the same cycle still belongs to the frame
- tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y  output  XW each  latched corner coordinates
- corners_valid  output  1  latched frame had at least MIN_PIXELS detected pixels
- pixel_count  output  19  latched detected-pixel count, saturating at 2^19-1
- frame_done  output  1  one-cycle pulse when the latched outputs update

## Operation

- Metrics per pixel, XW+1 bits:
  - s = x + y, unsigned.
  - d = x - y, two's-complement signed.
- Corner rules:
  - TL = minimum s.
  - BR = maximum s.
  - TR = maximum d.
  - BL = minimum d.
- Comparisons are strict. On a tie, the first pixel in arrival order is kept.
- Accumulator initial values:
  - s_min = all ones; s_max = 0.
  - d_max = most-negative; d_min = most-positive.
  - Coordinate registers = 0; count = 0.
  - A `hit` flag = 0.
- Pipeline:
  - Stage 1 registers pixel_valid & detected, x, y and frame_end, and computes s and d.
  - Stage 2 compares and updates the accumulators.
- State machine:
  - WAIT_SOF:
    - Entered at reset.
    - Pixels and frame_end are ignored.
    - frame_start → ACCUM, with accumulators initialised.
  - ACCUM:
    - Each stage-2 qualified pixel updates the accumulators and increments count (saturating). It also sets hit.
    - Delayed frame_end → LATCH.
    - frame_start seen while in ACCUM aborts the partial frame: accumulators are re-initialised, the state stays ACCUM, and outputs are untouched.
  - LATCH (one cycle):
    - Copy all four corner pairs to the outputs.
    - pixel_count ← count.
    - corners_valid ← hit & (count ≥ MIN_PIXELS).
    - Pulse frame_done.
    - → WAIT_SOF.
- If frame_start coincides with LATCH, it is honoured: the state goes to ACCUM and the accumulators are re-initialised after the copy.
- Frames with no detected pixels latch all corners as 0, with corners_valid = 0 and pixel_count = 0.
- reset:
  - Clears both pipeline stages, the accumulators and all outputs.
  - The state machine returns to WAIT_SOF.
  - A frame in progress is discarded; output resumes after the next full frame.

## Timing

- Reset values: all corner outputs 0, corners_valid 0, pixel_count 0, frame_done 0.
- frame_end in cycle N gives frame_done high in cycle N+2. Outputs change in that same cycle and hold until the next frame_done.
- A pixel accepted in cycle N affects the accumulators from cycle N+2.
- Back-to-back frames: frame_start may arrive in any cycle ≥ N+1. If it arrives at N+1 it is registered in the ACCUM-entry path, and no pixel may precede it.
- Fully pipelined: one pixel per clock, no backpressure, no ready signal.
- Overflow: s uses XW+1 bits, so no wrap occurs. The count saturates at 2^19-1 and never wraps.

## Test plan

- Single pixel: frame with one detected pixel at (100,50), MIN_PIXELS=1. Required:
  - All four corners = (100,50).
  - pixel_count = 1, corners_valid = 1.
  - frame_done at N+2.
- Quadrilateral: detected pixels at (10,20), (600,15), (5,400), (630,470) plus 20 interior hits. Required:
  - TL = (10,20), TR = (600,15), BL = (5,400), BR = (630,470).
  - pixel_count = 24, corners_valid = 1.
- Tie and order: detected pixels (5,5) then (4,6), which share s = 10. Required: TL = (5,5).
- Sparse frame: 15 detected pixels with MIN_PIXELS = 16. Required: corners_valid = 0 and pixel_count = 15; the corners are still latched.
- Boundary pulses: a detected pixel (639,479) presented in the same cycle as frame_end. Required: BR = (639,479).
- Abort and reset:
  - frame_start mid-frame discards earlier hits: only pixels after it are reported.
  - reset asserted mid-frame: all outputs read 0, and no frame_done occurs until a full frame_start…frame_end sequence completes.
